fw_ip_cfg_chain: RTL and testbench

Parametrised successor to the per-DUT firmware IP slots. It owns the DUT configuration shift chain and drives fw_config_clk, fw_config_in, fw_config_load and fw_reset_not. It buffers a CFG_BITS-long configuration written by SW in 16-bit words, shifts it into the DUT with a programmable clock divider, captures fw_config_out as readback, then issues a load strobe. It sits between common_sw_to_fw_side (op-code strobes) and common_fw_to_dut_side (DUT pins).

---
 rtl/fw_ip_cfg_chain.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_fw_ip_cfg_chain.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_ip_cfg_chain.sv
// fw_ip_cfg_chain: owns the DUT configuration shift chain.
// SW fills cfg_buf in 16-bit words. On execute the buffer is shifted LSB-first into the
// DUT through a divided config clock, fw_config_out is captured into rb_buf, and a load
// strobe follows. A separate counter drives the DUT reset pulse.
// Build macro FW_IP_CFG_CHAIN_READBACK_CHECK_EN: keeps a shadow of the last loaded
// configuration and raises sticky MISM when the next readback differs from it.
module fw_ip_cfg_chain #(
  parameter int unsigned CFG_BITS    = 256,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned RST_CYCLES  = 8
) (
  input  logic        fw_clk,
  input  logic        fw_rst_n,
  input  logic        fw_dev_id_enable,
  input  logic        fw_op_code_w_reset,
  input  logic        fw_op_code_w_cfg_array_0,
  input  logic        fw_op_code_r_cfg_array_0,
  input  logic        fw_op_code_r_cfg_array_1,
  input  logic        fw_op_code_w_status_clear,
  input  logic        fw_op_code_w_execute,
  input  logic [23:0] sw_write24_0,
  output logic [31:0] fw_read_data32,
  output logic [31:0] fw_read_status32,
  output logic        fw_config_clk,
  output logic        fw_config_in,
  output logic        fw_config_load,
  output logic        fw_reset_not,
  input  logic        fw_config_out
);

  localparam int unsigned NW    = CFG_BITS / 16;
  localparam int unsigned PW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned CW    = $clog2(CFG_BITS);
  localparam int unsigned PhMax = (CLK_DIV > LOAD_CYCLES) ? CLK_DIV : LOAD_CYCLES;
  localparam int unsigned PHW   = $clog2(PhMax + 1);
  localparam int unsigned RCW   = $clog2(RST_CYCLES + 1);

  localparam logic [PW-1:0]  PtrLast  = PW'(NW - 1);
  localparam logic [CW-1:0]  BitLast  = CW'(CFG_BITS - 1);
  localparam logic [PHW-1:0] DivLast  = PHW'(CLK_DIV - 1);
  localparam logic [PHW-1:0] LoadLast = PHW'(LOAD_CYCLES - 1);
  localparam logic [RCW-1:0] RstLen   = RCW'(RST_CYCLES);

  // Elaboration-time parameter sanity checks.
  if (CFG_BITS < 16 || (CFG_BITS % 16) != 0) begin : g_bad_cfg_bits
    $error("CFG_BITS must be a multiple of 16 and at least 16");
  end
  if (CLK_DIV < 1 || LOAD_CYCLES < 1 || RST_CYCLES < 1) begin : g_bad_cycles
    $error("CLK_DIV, LOAD_CYCLES and RST_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLoad, StDone} state_e;

  state_e         state_q, state_d;
  logic [PHW-1:0] ph_q, ph_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic           done_q, err_q, wrap_q;
  logic           cfg_clk_q, cfg_clk_d;
  logic           cfg_in_q, cfg_in_d;
  logic           load_n_q, load_n_d;
  logic           rst_n_q;
  logic [31:0]    rdata_q;
  logic           mism;

  logic [CFG_BITS-1:0] cfg_q;
  logic [CFG_BITS-1:0] rb_q;

  // Op-code decode with fixed priority: clear > reset > execute > write > read.
  logic do_clr, do_rst, do_exe, do_wr, do_rd0, do_rd1;
  logic busy, start, exe_err, wr_ok, wr_err, rd_any, abort;
  logic sample_en, load_enter, done_set;

  assign do_clr = fw_dev_id_enable & fw_op_code_w_status_clear;
  assign do_rst = fw_dev_id_enable & fw_op_code_w_reset & ~fw_op_code_w_status_clear;
  assign do_exe = fw_dev_id_enable & fw_op_code_w_execute & ~fw_op_code_w_status_clear &
                  ~fw_op_code_w_reset;
  assign do_wr  = fw_dev_id_enable & fw_op_code_w_cfg_array_0 & ~fw_op_code_w_status_clear &
                  ~fw_op_code_w_reset & ~fw_op_code_w_execute;
  assign do_rd0 = fw_dev_id_enable & fw_op_code_r_cfg_array_0 & ~fw_op_code_w_status_clear &
                  ~fw_op_code_w_reset & ~fw_op_code_w_execute & ~fw_op_code_w_cfg_array_0;
  assign do_rd1 = fw_dev_id_enable & fw_op_code_r_cfg_array_1 & ~fw_op_code_w_status_clear &
                  ~fw_op_code_w_reset & ~fw_op_code_w_execute & ~fw_op_code_w_cfg_array_0 &
                  ~fw_op_code_r_cfg_array_0;

  assign busy    = (state_q != StIdle);
  assign start   = do_exe & sw_write24_0[0] & ~busy;
  assign exe_err = do_exe & sw_write24_0[0] & busy;
  assign wr_ok   = do_wr & ~busy;
  assign wr_err  = do_wr & busy;
  assign rd_any  = do_rd0 | do_rd1;
  assign abort   = do_clr | do_rst;

  // Upper payload bits are not used by this block.
  logic unused_payload;
  assign unused_payload = ^sw_write24_0[23:16];

  // Shift FSM next-state: divider phase, bit counter and one-cycle event pulses.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_cnt_d  = bit_cnt_q;
    sample_en  = 1'b0;
    load_enter = 1'b0;
    done_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSetup;
          ph_d      = '0;
          bit_cnt_d = '0;
        end
      end
      StSetup: begin
        if (ph_q == DivLast) begin
          state_d = StHigh;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StHigh: begin
        sample_en = (ph_q == '0);
        if (ph_q == DivLast) begin
          ph_d = '0;
          if (bit_cnt_q == BitLast) begin
            state_d    = StLoad;
            load_enter = 1'b1;
          end else begin
            state_d   = StSetup;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StLoad: begin
        if (ph_q == LoadLast) begin
          state_d = StDone;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StDone: begin
        done_set = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Clear and DUT reset both abandon any shift in progress.
    if (abort) begin
      state_d    = StIdle;
      ph_d       = '0;
      sample_en  = 1'b0;
      load_enter = 1'b0;
      done_set   = 1'b0;
    end
  end

  // Pin drivers are registered from the next state so they never glitch.
  always_comb begin
    cfg_clk_d = (state_d == StHigh);
    load_n_d  = (state_d != StLoad);
    cfg_in_d  = (state_d == StSetup) ? cfg_q[bit_cnt_d] : cfg_in_q;
    rst_cnt_d = rst_cnt_q;
    if (do_rst) begin
      rst_cnt_d = RstLen;
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - 1'b1;
    end
  end

  // FSM, counters and DUT pin registers.
  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_q   <= StIdle;
      ph_q      <= '0;
      bit_cnt_q <= '0;
      rst_cnt_q <= '0;
      cfg_clk_q <= 1'b0;
      cfg_in_q  <= 1'b0;
      load_n_q  <= 1'b1;
      rst_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_cnt_q <= bit_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      cfg_clk_q <= cfg_clk_d;
      cfg_in_q  <= cfg_in_d;
      load_n_q  <= load_n_d;
      rst_n_q   <= (rst_cnt_d == '0);
    end
  end

  // Pointers, sticky flags and read data.
  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (do_clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        wrap_q   <= 1'b0;
      end else begin
        if (wr_ok) begin
          wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_any) begin
          rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        if ((wr_ok && wr_ptr_q == PtrLast) || (rd_any && rd_ptr_q == PtrLast)) begin
          wrap_q <= 1'b1;
        end
        if (start) begin
          done_q <= 1'b0;
        end else if (done_set) begin
          done_q <= 1'b1;
        end
        if (do_rst || exe_err || wr_err) begin
          err_q <= 1'b1;
        end
      end
      if (do_rd0) begin
        rdata_q <= {16'h0, cfg_q[{rd_ptr_q, 4'h0} +: 16]};
      end else if (do_rd1) begin
        rdata_q <= {16'h0, rb_q[{rd_ptr_q, 4'h0} +: 16]};
      end
    end
  end

  // Buffer storage has no reset; contents are defined only once written.
  always_ff @(posedge fw_clk) begin
    if (wr_ok) begin
      cfg_q[{wr_ptr_q, 4'h0} +: 16] <= sw_write24_0[15:0];
    end
    if (sample_en) begin
      rb_q[bit_cnt_q] <= fw_config_out;
    end
  end

`ifdef FW_IP_CFG_CHAIN_READBACK_CHECK_EN
  logic [CFG_BITS-1:0] shadow_q;
  logic                shadow_vld_q;
  logic                mism_q;

  // Snapshot of the configuration that was just loaded; storage needs no reset.
  always_ff @(posedge fw_clk) begin
    if (load_enter) begin
      shadow_q <= cfg_q;
    end
  end

  // Readback compare is armed only once a full load has completed since clear/reset.
  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      shadow_vld_q <= 1'b0;
      mism_q       <= 1'b0;
    end else if (do_clr) begin
      shadow_vld_q <= 1'b0;
      mism_q       <= 1'b0;
    end else begin
      if (load_enter) begin
        shadow_vld_q <= 1'b1;
      end
      if (sample_en && shadow_vld_q && (fw_config_out != shadow_q[bit_cnt_q])) begin
        mism_q <= 1'b1;
      end
    end
  end

  assign mism = mism_q;
`else
  logic unused_load_enter;
  assign unused_load_enter = load_enter;
  assign mism = 1'b0;
`endif

  assign fw_read_status32 = {busy, done_q, err_q, wrap_q, mism, 11'(bit_cnt_q),
                             8'(wr_ptr_q), 8'(rd_ptr_q)};
  assign fw_read_data32   = rdata_q;
  assign fw_config_clk    = cfg_clk_q;
  assign fw_config_in     = cfg_in_q;
  assign fw_config_load   = load_n_q;
  assign fw_reset_not     = rst_n_q;

endmodule

// File: tb/tb_fw_ip_cfg_chain.sv
// Directed bench for fw_ip_cfg_chain (CFG_BITS=32, CLK_DIV=2, LOAD_CYCLES=2, RST_CYCLES=8).
// The DUT chain is modelled as a 32-bit shift register that latches data on the config
// clock rising edge and shifts on the falling edge, so its output is stable while high.
module tb_fw_ip_cfg_chain;

  localparam int unsigned CfgBits = 32;

`ifdef FW_IP_CFG_CHAIN_READBACK_CHECK_EN
  localparam logic [31:0] MismBit = 32'h0800_0000;
`else
  localparam logic [31:0] MismBit = 32'h0000_0000;
`endif

  localparam int OpRst = 0;
  localparam int OpWr  = 1;
  localparam int OpRd0 = 2;
  localparam int OpRd1 = 3;
  localparam int OpClr = 4;
  localparam int OpExe = 5;

  logic        fw_clk = 1'b0;
  logic        fw_rst_n;
  logic        fw_dev_id_enable;
  logic        op_rst, op_wr, op_rd0, op_rd1, op_clr, op_exe;
  logic [23:0] sw_write24_0;
  logic [31:0] fw_read_data32, fw_read_status32;
  logic        fw_config_clk, fw_config_in, fw_config_load, fw_reset_not;
  logic        fw_config_out;

  logic [31:0] dut_sr;
  logic        in_lat;
  logic [31:0] cap;
  int          rises, sp_err, load_lo, rst_lo, cyc, last_rise;
  int          nvec = 0;
  int          nerr = 0;
  int          k;

  always #5 fw_clk = ~fw_clk;

  fw_ip_cfg_chain #(
    .CFG_BITS   (CfgBits),
    .CLK_DIV    (2),
    .LOAD_CYCLES(2),
    .RST_CYCLES (8)
  ) u_dut (
    .fw_clk                   (fw_clk),
    .fw_rst_n                 (fw_rst_n),
    .fw_dev_id_enable         (fw_dev_id_enable),
    .fw_op_code_w_reset       (op_rst),
    .fw_op_code_w_cfg_array_0 (op_wr),
    .fw_op_code_r_cfg_array_0 (op_rd0),
    .fw_op_code_r_cfg_array_1 (op_rd1),
    .fw_op_code_w_status_clear(op_clr),
    .fw_op_code_w_execute     (op_exe),
    .sw_write24_0             (sw_write24_0),
    .fw_read_data32           (fw_read_data32),
    .fw_read_status32         (fw_read_status32),
    .fw_config_clk            (fw_config_clk),
    .fw_config_in             (fw_config_in),
    .fw_config_load           (fw_config_load),
    .fw_reset_not             (fw_reset_not),
    .fw_config_out            (fw_config_out)
  );

  assign fw_config_out = dut_sr[0];

  always @(posedge fw_clk) cyc++;

  // Chain model: latch on rise, shift on fall; also log bits and edge spacing.
  always @(posedge fw_config_clk) begin
    in_lat = fw_config_in;
    cap    = {fw_config_in, cap[31:1]};
    if (rises > 0 && (cyc - last_rise) != 4) sp_err++;
    last_rise = cyc;
    rises++;
  end

  always @(negedge fw_config_clk) dut_sr = {in_lat, dut_sr[31:1]};

  always @(negedge fw_clk) begin
    if (!fw_config_load) load_lo++;
    if (!fw_reset_not) rst_lo++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle strobe driven between falling edges; returns on the falling edge after.
  task automatic op(input int code, input logic [23:0] pl, input logic en);
    @(negedge fw_clk);
    fw_dev_id_enable = en;
    sw_write24_0     = pl;
    case (code)
      OpRst:   op_rst = 1'b1;
      OpWr:    op_wr  = 1'b1;
      OpRd0:   op_rd0 = 1'b1;
      OpRd1:   op_rd1 = 1'b1;
      OpClr:   op_clr = 1'b1;
      default: op_exe = 1'b1;
    endcase
    @(negedge fw_clk);
    {op_rst, op_wr, op_rd0, op_rd1, op_clr, op_exe} = '0;
    fw_dev_id_enable = 1'b0;
    sw_write24_0     = '0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!fw_read_status32[30] && n < 1000) begin
      @(negedge fw_clk);
      n++;
    end
  endtask

  initial begin
    fw_rst_n = 1'b0;
    fw_dev_id_enable = 1'b0;
    {op_rst, op_wr, op_rd0, op_rd1, op_clr, op_exe} = '0;
    sw_write24_0 = '0;
    dut_sr = '0; in_lat = 1'b0; cap = '0;
    rises = 0; sp_err = 0; load_lo = 0; rst_lo = 0; cyc = 0; last_rise = 0;

    // Reset values
    #12;
    check("rst_status", fw_read_status32, 32'h0);
    check("rst_rdata", fw_read_data32, 32'h0);
    check("rst_load", {31'h0, fw_config_load}, 32'h1);
    check("rst_reset_not", {31'h0, fw_reset_not}, 32'h1);
    check("rst_cfg_clk", {31'h0, fw_config_clk}, 32'h0);
    @(negedge fw_clk);
    fw_rst_n = 1'b1;

    // Gated strobes do nothing
    op(OpWr, 24'h007777, 1'b0);
    op(OpExe, 24'h000001, 1'b0);
    check("gate_status", fw_read_status32, 32'h0);

    // Fill both words: second write wraps wr_ptr and sets WRAP
    op(OpWr, 24'h00A5C3, 1'b1);
    op(OpWr, 24'h000F0F, 1'b1);
    check("fill_status", fw_read_status32, 32'h1000_0000);

    // Full shift with timing checks
    dut_sr = 32'h1234_5678;
    rises = 0; sp_err = 0; load_lo = 0; cap = '0;
    op(OpExe, 24'h000001, 1'b1);
    check("exec_busy", {31'h0, fw_read_status32[31]}, 32'h1);
    wait_done(k);
    check("exec_cycles", k, 131);
    check("exec_status", fw_read_status32, 32'h501F_0000);
    check("clk_rises", rises, 32);
    check("clk_spacing_err", sp_err, 0);
    check("cfg_in_bits", cap, 32'h0F0F_A5C3);
    check("load_low_cycles", load_lo, 2);
    check("dut_chain", dut_sr, 32'h0F0F_A5C3);

    // Readback of the previously held chain contents, then a cfg read
    op(OpRd1, 24'h0, 1'b1);
    check("rb_word0", fw_read_data32, 32'h0000_5678);
    op(OpRd1, 24'h0, 1'b1);
    check("rb_word1", fw_read_data32, 32'h0000_1234);
    op(OpRd0, 24'h0, 1'b1);
    check("cfg_word0", fw_read_data32, 32'h0000_A5C3);
    check("rd_status", fw_read_status32, 32'h501F_0001);

    // Re-execute the same data with a clean chain: no mismatch
    op(OpExe, 24'h000001, 1'b1);
    wait_done(k);
    check("reexec_status", fw_read_status32, 32'h501F_0001);

    // Corrupt one chain bit before the next shift
    dut_sr[5] = ~dut_sr[5];
    op(OpExe, 24'h000001, 1'b1);
    wait_done(k);
    check("mism_status", fw_read_status32, 32'h501F_0001 | MismBit);
    op(OpRd1, 24'h0, 1'b1);
    check("rb_corrupt_w1", fw_read_data32, 32'h0000_0F0F);

    // Busy collisions: write and execute ignored, ERR set
    op(OpClr, 24'h0, 1'b1);
    check("clr_status", fw_read_status32, 32'h001F_0000);
    op(OpExe, 24'h000001, 1'b1);
    repeat (10) @(negedge fw_clk);
    op(OpWr, 24'h00DEAD, 1'b1);
    op(OpExe, 24'h000001, 1'b1);
    check("busy_err", fw_read_status32 & 32'hE000_FF00, 32'hA000_0000);
    wait_done(k);
    op(OpClr, 24'h0, 1'b1);
    op(OpRd0, 24'h0, 1'b1);
    check("busy_word0", fw_read_data32, 32'h0000_A5C3);
    op(OpRd0, 24'h0, 1'b1);
    check("busy_word1", fw_read_data32, 32'h0000_0F0F);

    // DUT reset mid-shift aborts and pulses reset_not for 8 cycles
    op(OpExe, 24'h000001, 1'b1);
    repeat (20) @(negedge fw_clk);
    rst_lo = 0;
    op(OpRst, 24'h0, 1'b1);
    check("wrst_flags", {29'h0, fw_read_status32[31:29]}, 32'h1);
    check("wrst_pins", {28'h0, fw_reset_not, fw_config_clk, fw_config_load, 1'b0}, 32'h2);
    repeat (12) @(negedge fw_clk);
    check("wrst_width", rst_lo, 8);

    // Status clear mid-shift aborts without ERR
    op(OpExe, 24'h000001, 1'b1);
    repeat (20) @(negedge fw_clk);
    op(OpClr, 24'h0, 1'b1);
    check("sclr_status", fw_read_status32 & 32'hF800_FFFF, 32'h0);
    check("sclr_pins", {29'h0, fw_reset_not, fw_config_clk, fw_config_load}, 32'h5);

    // NW+1 writes wrap and overwrite word 0
    op(OpWr, 24'h00AAAA, 1'b1);
    op(OpWr, 24'h00BBBB, 1'b1);
    op(OpWr, 24'h00CCCC, 1'b1);
    check("wrap_status", fw_read_status32 & 32'hF800_FFFF, 32'h1000_0100);

    // Gated strobes and execute with bit0=0 leave state unchanged
    op(OpWr, 24'h007777, 1'b0);
    op(OpClr, 24'h0, 1'b0);
    op(OpExe, 24'h000001, 1'b0);
    op(OpExe, 24'h000000, 1'b1);
    check("gate2_status", fw_read_status32 & 32'hF800_FFFF, 32'h1000_0100);
    op(OpRd0, 24'h0, 1'b1);
    check("wrap_word0", fw_read_data32, 32'h0000_CCCC);
    op(OpRd0, 24'h0, 1'b1);
    check("wrap_word1", fw_read_data32, 32'h0000_BBBB);

    // Asynchronous reset mid-shift
    op(OpExe, 24'h000001, 1'b1);
    repeat (9) @(negedge fw_clk);
    #2 fw_rst_n = 1'b0;
    #1;
    check("arst_status", fw_read_status32, 32'h0);
    check("arst_pins", {28'h0, fw_reset_not, fw_config_clk, fw_config_load, 1'b0}, 32'hA);
    check("arst_rdata", fw_read_data32, 32'h0);
    @(negedge fw_clk);
    fw_rst_n = 1'b1;
    repeat (2) @(negedge fw_clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
